// File: rtl/dt_preimage_search.sv
// dt_preimage_search: sweeps every classifier input in ascending order and
// streams out each input whose classifier label equals the requested target.
module dt_preimage_search #(
    parameter int WIDTH   = 8,
    parameter int LABEL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [LABEL_W-1:0] target,
    input  logic               abort,
    output logic [WIDTH-1:0]   cand,
    input  logic [LABEL_W-1:0] cls_out,
    output logic               hit_valid,
    input  logic               hit_ready,
    output logic [WIDTH-1:0]   hit_data,
    output logic               busy,
    output logic               done,
    output logic [WIDTH:0]     hit_count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        FIN
    } state_t;

    localparam logic [WIDTH-1:0] LAST  = '1;
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam logic [WIDTH:0]   H_ONE = (WIDTH + 1)'(1);

    state_t             state;
    logic [LABEL_W-1:0] tgt;

    // Sweep controller: one candidate per SCAN cycle, parks in EMIT per hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tgt         <= '0;
            cand        <= '0;
            hit_valid   <= 1'b0;
            hit_data    <= '0;
            hit_count   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        tgt         <= target;
                        cand        <= '0;
                        hit_count   <= '0;
                        state       <= SCAN;
                        busy        <= 1'b1;
                        start_ready <= 1'b0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end else if (cls_out == tgt) begin
                        hit_data  <= cand;
                        hit_valid <= 1'b1;
                        hit_count <= hit_count + H_ONE;
                        state     <= EMIT;
                    end else if (cand == LAST) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cand <= cand + C_ONE;
                    end
                end
                EMIT: begin
                    if (abort) begin
                        hit_valid   <= 1'b0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end else if (hit_ready) begin
                        hit_valid <= 1'b0;
                        if (cand == LAST) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cand  <= cand + C_ONE;
                            state <= SCAN;
                        end
                    end
                end
                FIN: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dt_preimage_search.sv
// tb_dt_preimage_search: drives dt_preimage_search against a behavioural
// classifier and a list-of-preimages reference model.
module tb_dt_preimage_search;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] target;
    logic       abort;
    logic [7:0] cand;
    logic [7:0] cls_out;
    logic       hit_valid;
    logic       hit_ready;
    logic [7:0] hit_data;
    logic       busy;
    logic       done;
    logic [8:0] hit_count;

    int checks   = 0;
    int failures = 0;

    int         mode = 0;
    logic [7:0] lut [256];

    dt_preimage_search #(.WIDTH(8), .LABEL_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .target(target),
        .abort(abort),
        .cand(cand),
        .cls_out(cls_out),
        .hit_valid(hit_valid),
        .hit_ready(hit_ready),
        .hit_data(hit_data),
        .busy(busy),
        .done(done),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] x);
        case (mode)
            0:       return x & 8'h0F;
            1:       return 8'h5A;
            default: return lut[x];
        endcase
    endfunction

    // external combinational classifier
    always_comb cls_out = model(cand);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start_ready"}, start_ready, 1);
        chk({tag, "_cand"}, cand, 0);
        chk({tag, "_hit_valid"}, hit_valid, 0);
        chk({tag, "_hit_data"}, hit_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_hit_count"}, hit_count, 0);
    endtask

    // rmode: 0 ready high, 1 stall first hit 5 cycles, 2 random ready
    task automatic do_search(input logic [7:0] tgt, input int rmode,
                             input int abort_hit, input bit poke);
        int q[$];
        int nh, lows, dcyc, stalled;
        bit hr, ab;
        q = {};
        for (int i = 0; i < 256; i++)
            if (model(8'(i)) == tgt) q.push_back(i);
        @(negedge clk);
        chk("start_ready_idle", start_ready, 1);
        start_valid = 1'b1;
        target      = tgt;
        hit_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        target      = ~tgt;
        nh = 0; lows = 0; stalled = 0; dcyc = -1; ab = 1'b0;
        for (int k = 1; k < 800; k++) begin
            if (k == 1) chk("cand_start", cand, 0);
            if (done) begin
                dcyc = k;
                break;
            end
            chk("busy", busy, 1);
            if (poke) begin
                start_valid = (k % 5 == 0);
                chk("start_ready_busy", start_ready, 0);
            end
            hr = 1'b1;
            if (hit_valid) begin
                if (nh >= q.size()) begin
                    chk("extra_hit", hit_valid, 0);
                end else begin
                    chk("hit_data", hit_data, q[nh]);
                    chk("hit_cand", cand, q[nh]);
                    if (rmode == 1 && nh == 0 && stalled < 5) begin
                        hr = 1'b0;
                        stalled++;
                    end else if (rmode == 2) begin
                        hr = 1'($urandom_range(0, 1));
                    end
                    if (nh == abort_hit) begin
                        hr    = 1'b1;
                        ab    = 1'b1;
                        abort = 1'b1;
                    end
                end
                if (hr) nh++;
                else lows++;
            end
            hit_ready = hr;
            @(posedge clk);
            if (ab) break;
            @(negedge clk);
        end
        start_valid = 1'b0;
        hit_ready   = 1'b1;
        if (ab) begin
            @(negedge clk);
            abort = 1'b0;
            chk("abort_idle", start_ready, 1);
            chk("abort_busy", busy, 0);
            chk("abort_hit_valid", hit_valid, 0);
            chk("abort_done", done, 0);
            chk("abort_count", hit_count, abort_hit + 1);
            repeat (3) begin
                @(negedge clk);
                chk("abort_no_done", done, 0);
            end
            return;
        end
        if (rmode == 1) chk("stall_cycles", lows, 5);
        chk("done_cycle", dcyc, 256 + q.size() + lows + 1);
        chk("hits", nh, q.size());
        chk("hit_count", hit_count, q.size());
        repeat (3) begin
            @(negedge clk);
            chk("post_done", done, 0);
            chk("post_hit_valid", hit_valid, 0);
            chk("post_start_ready", start_ready, 1);
            chk("post_count_hold", hit_count, q.size());
        end
    endtask

    initial begin
        bit reached;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        target      = 8'h00;
        abort       = 1'b0;
        hit_ready   = 1'b1;
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        mode = 0;
        do_search(8'h03, 0, -1, 1'b0);
        do_search(8'h10, 0, -1, 1'b0);

        mode = 1;
        do_search(8'h5A, 0, -1, 1'b0);

        mode = 0;
        do_search(8'h03, 1, -1, 1'b1);
        do_search(8'h03, 0, 3, 1'b0);
        do_search(8'h03, 0, -1, 1'b0);

        // asynchronous reset in the middle of a sweep
        @(negedge clk);
        start_valid = 1'b1;
        target      = 8'h03;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        reached     = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (cand == 8'h80 && !hit_valid) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_scan_reached", cand, reached ? 8'h80 : 8'hxx);
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_search(8'h03, 0, -1, 1'b0);

        mode = 2;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++) lut[i] = 8'($urandom_range(0, 3));
            do_search(8'($urandom_range(0, 3)), 2, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
